wb_retire_unit: RTL and testbench

WB_RETIRE_UNIT -- requirements
Module: wb_retire_unit

---
 rtl/rv32i_types.sv | 15 +
 rtl/wb_fifo.sv | 57 +++++
 rtl/wb_retire_unit.sv | 133 +++++++++++++
 tb/tb_wb_retire_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types: write-back result kinds used by the retire path.
package rv32i_types;

  typedef enum logic [2:0] {
    WB_RAW = 3'd0,
    WB_LB  = 3'd1,
    WB_LBU = 3'd2,
    WB_LH  = 3'd3,
    WB_LHU = 3'd4
  } wb_kind_t;

  localparam int RD_W   = 5;
  localparam int KIND_W = 3;

endpackage

// File: rtl/wb_fifo.sv
// Single-clock FIFO holding pending write-back entries for one producer channel.
// Space is reported from the registered count only, so a same-cycle pop never frees a slot early.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign in_ready = (count != FULL);
  assign do_push  = in_valid && in_ready && !flush;
  assign do_pop   = pop && (count != '0) && !flush;
  assign head     = mem[rptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= in_data;
  end

endmodule

// File: rtl/wb_retire_unit.sv
// Retires buffered results from several producers onto one register-file write port,
// using round-robin arbitration and load-data byte/halfword extraction.
module wb_retire_unit
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int N_SRC = 2,
  parameter int DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [N_SRC-1:0]                      src_valid,
  output logic [N_SRC-1:0]                      src_ready,
  input  logic [N_SRC*5-1:0]                    src_rd,
  input  logic [N_SRC*3-1:0]                    src_kind,
  input  logic [N_SRC*$clog2(XLEN/8)-1:0]       src_offset,
  input  logic [N_SRC*XLEN-1:0]                 src_data,
  output logic                                  wb_load,
  output logic [4:0]                            wb_rd,
  output logic [XLEN-1:0]                       wb_data,
  output logic [N_SRC*($clog2(DEPTH)+1)-1:0]    occupancy
);

  localparam int OFFW = $clog2(XLEN/8);
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int PW   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int EW   = RD_W + KIND_W + OFFW + XLEN;

  logic [EW-1:0]    head [N_SRC];
  logic [N_SRC-1:0] nonempty;
  logic [N_SRC-1:0] pop;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    grant_idx;
  logic             grant_any;

  for (genvar i = 0; i < N_SRC; i++) begin : g_ch
    logic [CW-1:0] cnt;

    wb_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (src_valid[i]),
      .in_ready (src_ready[i]),
      .in_data  ({src_rd[i*RD_W +: RD_W], src_kind[i*KIND_W +: KIND_W],
                  src_offset[i*OFFW +: OFFW], src_data[i*XLEN +: XLEN]}),
      .pop      (pop[i]),
      .head     (head[i]),
      .count    (cnt)
    );

    assign nonempty[i]            = (cnt != '0);
    assign occupancy[i*CW +: CW]  = cnt;
    assign pop[i]                 = grant_any && !flush && (grant_idx == PW'(i));
  end

  // Scanning downward lets the lowest index win; the "hi" candidate is restricted to
  // indices at or above rr_ptr, and the unrestricted one covers the wrap-around case.
  logic          hi_found;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;

  always_comb begin
    hi_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    grant_any = 1'b0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (nonempty[k]) begin
        if (k >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = PW'(k);
        end
        grant_any = 1'b1;
        lo_idx    = PW'(k);
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  logic [EW-1:0]   sel;
  logic [4:0]      sel_rd;
  logic [2:0]      sel_kind;
  logic [OFFW-1:0] sel_off;
  logic [XLEN-1:0] sel_data;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;
  logic [XLEN-1:0] ext_data;

  assign sel      = head[grant_idx];
  assign sel_rd   = sel[EW-1 -: RD_W];
  assign sel_kind = sel[EW-RD_W-1 -: KIND_W];
  assign sel_off  = sel[XLEN +: OFFW];
  assign sel_data = sel[XLEN-1:0];

  // Halfword selection ignores offset bit 0; unknown kinds fall through as raw.
  always_comb begin
    byte_val = 8'(sel_data >> {sel_off, 3'b000});
    half_val = 16'(sel_data >> {sel_off[OFFW-1:1], 4'b0000});
    ext_data = sel_data;
    case (sel_kind)
      WB_LB:   ext_data = {{(XLEN-8){byte_val[7]}}, byte_val};
      WB_LBU:  ext_data = {{(XLEN-8){1'b0}}, byte_val};
      WB_LH:   ext_data = {{(XLEN-16){half_val[15]}}, half_val};
      WB_LHU:  ext_data = {{(XLEN-16){1'b0}}, half_val};
      default: ext_data = sel_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_load <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      rr_ptr  <= '0;
    end else if (flush) begin
      wb_load <= 1'b0;
      rr_ptr  <= '0;
    end else if (grant_any) begin
      wb_load <= (sel_rd != '0);
      wb_rd   <= sel_rd;
      wb_data <= ext_data;
      rr_ptr  <= (grant_idx == PW'(N_SRC - 1)) ? '0 : grant_idx + 1'b1;
    end else begin
      wb_load <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_retire_unit.sv
// Directed bench for wb_retire_unit: extraction vectors plus arbitration, backpressure, flush and reset sequences.
module tb_wb_retire_unit;
  import rv32i_types::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  src_valid;
  logic [1:0]  src_ready;
  logic [9:0]  src_rd;
  logic [5:0]  src_kind;
  logic [3:0]  src_offset;
  logic [63:0] src_data;
  logic        wb_load;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [5:0]  occupancy;

  int check_count = 0;
  int pass_count  = 0;

  wb_retire_unit #(.XLEN(32), .N_SRC(2), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_rd     (src_rd),
    .src_kind   (src_kind),
    .src_offset (src_offset),
    .src_data   (src_data),
    .wb_load    (wb_load),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [4:0]  rd;
    logic [2:0]  kind;
    logic [1:0]  off;
    logic [31:0] data;
    logic        exp_load;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clearInputs();
    src_valid  = '0;
    src_rd     = '0;
    src_kind   = '0;
    src_offset = '0;
    src_data   = '0;
  endtask

  task automatic applyStimulus(input int ch, input logic [4:0] rd, input logic [2:0] kind,
                               input logic [1:0] off, input logic [31:0] data);
    src_valid[ch]          = 1'b1;
    src_rd[ch*5 +: 5]      = rd;
    src_kind[ch*3 +: 3]    = kind;
    src_offset[ch*2 +: 2]  = off;
    src_data[ch*32 +: 32]  = data;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic doFlush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] order [6];
    logic [2:0] occ0_exp [7];
    logic [2:0] occ1_exp [7];

    vecs[0] = '{0, 5'd5,  WB_LB,  2'd2, 32'h80FF_1234, 1'b1, 32'hFFFF_FFFF};
    vecs[1] = '{1, 5'd7,  WB_LHU, 2'd3, 32'hBEEF_0000, 1'b1, 32'h0000_BEEF};
    vecs[2] = '{0, 5'd1,  WB_RAW, 2'd0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1, 5'd2,  WB_LBU, 2'd3, 32'h80FF_1234, 1'b1, 32'h0000_0080};
    vecs[4] = '{0, 5'd3,  WB_LH,  2'd0, 32'h1234_8765, 1'b1, 32'hFFFF_8765};
    vecs[5] = '{1, 5'd4,  WB_LH,  2'd2, 32'h7FFF_0000, 1'b1, 32'h0000_7FFF};
    vecs[6] = '{0, 5'd6,  WB_LB,  2'd0, 32'h0000_007F, 1'b1, 32'h0000_007F};
    vecs[7] = '{0, 5'd8,  3'd7,   2'd1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
    vecs[8] = '{1, 5'd0,  WB_RAW, 2'd0, 32'h0000_1234, 1'b0, 32'h0000_1234};
    vecs[9] = '{0, 5'd31, WB_LBU, 2'd1, 32'h0000_AB00, 1'b1, 32'h0000_00AB};

    order    = '{5'd10, 5'd20, 5'd11, 5'd21, 5'd12, 5'd22};
    occ0_exp = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};
    occ1_exp = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd3};

    rst   = 1'b0;
    flush = 1'b0;
    clearInputs();
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_wb_load", wb_load, 0);
    checkOutput("reset_wb_rd", wb_rd, 0);
    checkOutput("reset_wb_data", wb_data, 0);
    checkOutput("reset_occupancy", occupancy, 0);
    checkOutput("reset_src_ready", src_ready, 2'b11);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("post_reset_wb_load", wb_load, 0);
    checkOutput("post_reset_src_ready", src_ready, 2'b11);

    // Single entries through the pipeline: push, grant, then one-cycle write pulse.
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].ch, vecs[v].rd, vecs[v].kind, vecs[v].off, vecs[v].data);
      tick();
      clearInputs();
      tick();
      checkOutput($sformatf("vec%0d_wb_load", v), wb_load, vecs[v].exp_load);
      checkOutput($sformatf("vec%0d_wb_rd", v), wb_rd, vecs[v].rd);
      checkOutput($sformatf("vec%0d_wb_data", v), wb_data, vecs[v].exp_data);
      checkOutput($sformatf("vec%0d_occupancy", v), occupancy, 0);
      tick();
      checkOutput($sformatf("vec%0d_idle_load", v), wb_load, 0);
      checkOutput($sformatf("vec%0d_hold_data", v), wb_data, vecs[v].exp_data);
    end

    // Round-robin alternation with back-to-back writes.
    doFlush();
    for (int k = 0; k < 7; k++) begin
      clearInputs();
      if (k < 3) begin
        applyStimulus(0, 5'(10 + k), WB_RAW, 2'd0, 32'(k));
        applyStimulus(1, 5'(20 + k), WB_RAW, 2'd0, 32'(k));
      end
      tick();
      if (k >= 1) begin
        checkOutput($sformatf("rr%0d_wb_load", k - 1), wb_load, 1);
        checkOutput($sformatf("rr%0d_wb_rd", k - 1), wb_rd, order[k-1]);
      end
    end
    clearInputs();
    tick();
    checkOutput("rr_drained_load", wb_load, 0);

    // Backpressure: both channels push every cycle until channel 0 fills.
    doFlush();
    for (int k = 0; k < 7; k++) begin
      clearInputs();
      applyStimulus(0, 5'(1 + k), WB_RAW, 2'd0, 32'(k));
      applyStimulus(1, 5'(16 + k), WB_RAW, 2'd0, 32'(k));
      tick();
      checkOutput($sformatf("fill%0d_occ0", k), occupancy[2:0], occ0_exp[k]);
      checkOutput($sformatf("fill%0d_occ1", k), occupancy[5:3], occ1_exp[k]);
    end
    checkOutput("full_src_ready", src_ready, 2'b10);
    clearInputs();
    applyStimulus(0, 5'd29, WB_RAW, 2'd0, 32'h99);
    tick();
    checkOutput("full_push_dropped_occ0", occupancy[2:0], 3'd3);
    checkOutput("full_grant_load", wb_load, 1);
    clearInputs();
    for (int k = 0; k < 8; k++) tick();
    checkOutput("fill_drained_occ", occupancy, 0);

    // Flush with queued entries and a concurrent push.
    doFlush();
    applyStimulus(0, 5'd3, WB_RAW, 2'd0, 32'h33);
    applyStimulus(1, 5'd4, WB_RAW, 2'd0, 32'h44);
    tick();
    checkOutput("preflush_occ", occupancy, 6'b001_001);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clearInputs();
    checkOutput("flush_occ", occupancy, 0);
    checkOutput("flush_wb_load", wb_load, 0);
    tick();
    checkOutput("postflush_wb_load", wb_load, 0);
    checkOutput("postflush_occ", occupancy, 0);

    // Asynchronous reset in the middle of traffic.
    applyStimulus(0, 5'd9, WB_RAW, 2'd0, 32'h5555_AAAA);
    applyStimulus(1, 5'd10, WB_RAW, 2'd0, 32'h1111_2222);
    tick();
    tick();
    checkOutput("midrst_pre_load", wb_load, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_wb_load", wb_load, 0);
    checkOutput("midrst_wb_rd", wb_rd, 0);
    checkOutput("midrst_wb_data", wb_data, 0);
    checkOutput("midrst_occ", occupancy, 0);
    checkOutput("midrst_src_ready", src_ready, 2'b11);
    clearInputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("after_rst_wb_load", wb_load, 0);
    checkOutput("after_rst_occ", occupancy, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
